// File: rtl/bcd_digit_serializer.sv
// Converts a captured frame of BCD counter digits into ASCII characters.
// Characters go out most significant digit first over a valid/ready handshake.
module bcd_digit_serializer #(
    parameter int DIGITS_NUM    = 6,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk_in,
    input  logic                    reset_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic                    overflow_in,
    input  logic                    capture_in,
    output logic [7:0]              char_out,
    output logic                    char_valid_out,
    input  logic                    char_ready_in,
    output logic                    frame_first_out,
    output logic                    frame_last_out,
    output logic                    busy_out,
    output logic                    capture_dropped_out
);

    localparam int IW = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam logic [IW-1:0] FIRST_IDX = IW'(DIGITS_NUM - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state, w_state_next;
    logic [4*DIGITS_NUM-1:0] r_snap_digits, w_snap_digits_next;
    logic                    r_snap_ovf, w_snap_ovf_next;
    logic [IW-1:0]           r_index, w_index_next;
    logic                    r_dropped, w_dropped_next;

    logic [DIGITS_NUM-1:0]   w_digit_zero;
    logic [DIGITS_NUM-1:0]   w_blank;
    logic                    w_run_zero;
    logic [3:0]              w_cur_digit;
    logic                    w_cur_blank;
    logic                    w_transfer;
    logic                    w_is_last;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS_NUM; gi++) begin : g_digit_zero
            assign w_digit_zero[gi] = (r_snap_digits[4*gi +: 4] == 4'd0);
        end
    endgenerate

    // A zero is blanked only while every more significant digit is also zero.
    always_comb begin
        w_run_zero = 1'b1;
        w_blank    = '0;
        for (int i = DIGITS_NUM - 1; i >= 0; i--) begin
            w_run_zero = w_run_zero & w_digit_zero[i];
            w_blank[i] = (BLANK_LEADING != 0) && (i != 0) && w_run_zero;
        end
    end

    always_comb begin
        w_cur_digit = 4'd0;
        w_cur_blank = 1'b0;
        for (int i = 0; i < DIGITS_NUM; i++) begin
            if (r_index == IW'(i)) begin
                w_cur_digit = r_snap_digits[4*i +: 4];
                w_cur_blank = w_blank[i];
            end
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state       <= IDLE;
            r_snap_digits <= '0;
            r_snap_ovf    <= 1'b0;
            r_index       <= FIRST_IDX;
            r_dropped     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_snap_digits <= w_snap_digits_next;
            r_snap_ovf    <= w_snap_ovf_next;
            r_index       <= w_index_next;
            r_dropped     <= w_dropped_next;
        end
    end

    assign w_is_last  = (r_index == '0);
    assign w_transfer = (r_state == SEND) && char_ready_in;

    always_comb begin
        w_state_next       = r_state;
        w_snap_digits_next = r_snap_digits;
        w_snap_ovf_next    = r_snap_ovf;
        w_index_next       = r_index;
        w_dropped_next     = 1'b0;

        char_out        = 8'h00;
        char_valid_out  = 1'b0;
        frame_first_out = 1'b0;
        frame_last_out  = 1'b0;
        busy_out        = 1'b0;

        case (r_state)
            IDLE: begin
                if (capture_in) begin
                    w_snap_digits_next = digits_in;
                    w_snap_ovf_next    = overflow_in;
                    w_index_next       = FIRST_IDX;
                    w_state_next       = SEND;
                end
            end
            SEND: begin
                busy_out        = 1'b1;
                char_valid_out  = 1'b1;
                frame_first_out = (r_index == FIRST_IDX);
                frame_last_out  = w_is_last;
                if (r_snap_ovf)
                    char_out = 8'h2D;
                else if (w_cur_digit > 4'd9)
                    char_out = 8'h3F;
                else if (w_cur_blank)
                    char_out = 8'h20;
                else
                    char_out = 8'h30 + {4'h0, w_cur_digit};

                // Only the final transfer of a frame may chain straight into a new capture.
                if (w_transfer && w_is_last) begin
                    if (capture_in) begin
                        w_snap_digits_next = digits_in;
                        w_snap_ovf_next    = overflow_in;
                        w_index_next       = FIRST_IDX;
                    end else begin
                        w_index_next = FIRST_IDX;
                        w_state_next = IDLE;
                    end
                end else begin
                    if (w_transfer)
                        w_index_next = r_index - IW'(1);
                    w_dropped_next = capture_in;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign capture_dropped_out = r_dropped;

endmodule
